// File: rtl/sig_debounce.sv
// Debounces a synchronized level: out follows in only after STABLE_CYCLES
// consecutive differing samples; aborted transitions are counted as glitches.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_STABLE_LO | out=0, in agrees with out (counter idle at 0)
// ST_PEND_HI   | out=0, in has read 1 for r_cnt consecutive samples
// ST_STABLE_HI | out=1, in agrees with out (counter idle at 0)
// ST_PEND_LO   | out=1, in has read 0 for r_cnt consecutive samples
module sig_debounce #(
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_W         = 16,
  parameter int   GLITCH_W      = 8,
  parameter logic RST_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in,
  input  logic                glitch_clr,
  output logic                out,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if (STABLE_CYCLES < 1 || (CNT_W < 31 && STABLE_CYCLES > (2 ** CNT_W))) begin : g_param_check
    $error("sig_debounce: STABLE_CYCLES must lie in 1 .. 2**CNT_W");
  end

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_PEND_HI   = 2'b01,
    ST_STABLE_HI = 2'b10,
    ST_PEND_LO   = 2'b11
  } state_t;

  localparam state_t          RST_STATE = RST_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;
  localparam logic [CNT_W-1:0] TERM     = CNT_W'(STABLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_out;
  logic                r_rise;
  logic                r_fall;
  logic                r_busy;
  logic [GLITCH_W-1:0] r_glitch_cnt;
  logic                w_differ;
  logic                w_rise_nxt;
  logic                w_fall_nxt;
  logic                w_glitch;
  logic                w_out_nxt;
  logic                w_busy_nxt;

  assign w_differ = (in != r_out);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_glitch    = 1'b0;
    case (r_state)
      ST_STABLE_LO: begin
        w_cnt_nxt = '0;
        if (w_differ) begin
          if (STABLE_CYCLES == 1) begin
            w_state_nxt = ST_STABLE_HI;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_PEND_HI;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_PEND_HI: begin
        if (!w_differ) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
          w_glitch    = 1'b1;
        end else if (r_cnt == TERM) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_STABLE_HI: begin
        w_cnt_nxt = '0;
        if (w_differ) begin
          if (STABLE_CYCLES == 1) begin
            w_state_nxt = ST_STABLE_LO;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_PEND_LO;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_PEND_LO: begin
        if (!w_differ) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
          w_glitch    = 1'b1;
        end else if (r_cnt == TERM) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RST_STATE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // out and busy are pure decodes of the next state, registered with it
  assign w_out_nxt  = (w_state_nxt == ST_STABLE_HI) || (w_state_nxt == ST_PEND_LO);
  assign w_busy_nxt = (w_state_nxt == ST_PEND_HI)   || (w_state_nxt == ST_PEND_LO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_out   <= RST_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // clear beats a coincident glitch; the count sticks at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign out        = r_out;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign busy       = r_busy;
  assign glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_sig_debounce.sv
// Bench for sig_debounce: two instances (4-cycle/reset-low and 1-cycle/reset-high)
// driven identically and compared every cycle against a run-length reference model.
module tb_sig_debounce;

  localparam int SC0 = 4;
  localparam int SC1 = 1;
  localparam int GW  = 2;
  localparam int GMAX = (1 << GW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in;
  logic          glitch_clr;
  logic          out0, rise0, fall0, busy0;
  logic [GW-1:0] gc0;
  logic          out1, rise1, fall1, busy1;
  logic [GW-1:0] gc1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, index 0 / 1 per instance
  bit m_out   [2];
  bit m_rise  [2];
  bit m_fall  [2];
  bit m_busy  [2];
  int m_run   [2];
  int m_gc    [2];

  sig_debounce #(.STABLE_CYCLES(SC0), .CNT_W(16), .GLITCH_W(GW), .RST_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in), .glitch_clr(glitch_clr),
    .out(out0), .rise(rise0), .fall(fall0), .busy(busy0), .glitch_cnt(gc0)
  );

  sig_debounce #(.STABLE_CYCLES(SC1), .CNT_W(4), .GLITCH_W(GW), .RST_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in), .glitch_clr(glitch_clr),
    .out(out1), .rise(rise1), .fall(fall1), .busy(busy1), .glitch_cnt(gc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock edge of the rules: out flips after `sc` consecutive differing samples
  task automatic model_edge(input int k, input int sc, input bit rl,
                            input bit i_v, input bit clr, input bit rn);
    bit glitch;
    glitch = 1'b0;
    if (!rn) begin
      m_out[k] = rl; m_run[k] = 0; m_gc[k] = 0;
      m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_busy[k] = 1'b0;
    end else begin
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      if (i_v != m_out[k]) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == sc) begin
          m_out[k]  = ~m_out[k];
          m_rise[k] = m_out[k];
          m_fall[k] = ~m_out[k];
          m_run[k]  = 0;
        end
      end else begin
        glitch   = (m_run[k] > 0);
        m_run[k] = 0;
      end
      m_busy[k] = (m_run[k] > 0);
      if (clr) m_gc[k] = 0;
      else if (glitch && m_gc[k] < GMAX) m_gc[k] = m_gc[k] + 1;
    end
  endtask

  task automatic step(input bit i_v, input bit clr, input bit rn);
    in = i_v; glitch_clr = clr; rst_n = rn;
    @(posedge clk);
    model_edge(0, SC0, 1'b0, i_v, clr, rn);
    model_edge(1, SC1, 1'b1, i_v, clr, rn);
    #1;
    chk("out0",  32'(out0),  32'(m_out[0]));
    chk("rise0", 32'(rise0), 32'(m_rise[0]));
    chk("fall0", 32'(fall0), 32'(m_fall[0]));
    chk("busy0", 32'(busy0), 32'(m_busy[0]));
    chk("gc0",   32'(gc0),   32'(m_gc[0]));
    chk("out1",  32'(out1),  32'(m_out[1]));
    chk("rise1", 32'(rise1), 32'(m_rise[1]));
    chk("fall1", 32'(fall1), 32'(m_fall[1]));
    chk("busy1", 32'(busy1), 32'(m_busy[1]));
    chk("gc1",   32'(gc1),   32'(m_gc[1]));
    chk("excl0", 32'(rise0 & fall0), 32'(0));
    chk("excl1", 32'(rise1 & fall1), 32'(0));
  endtask

  initial begin
    bit cur;
    int hold;
    in = 1'b0; glitch_clr = 1'b0; rst_n = 1'b0;
    @(negedge clk);

    // reset values
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_out0", 32'(out0), 32'(0));
    chk("rst_out1", 32'(out1), 32'(1));
    chk("rst_gc0",  32'(gc0),  32'(0));

    // rise after four held samples
    step(1, 0, 1);
    chk("r_busy_a", 32'(busy0), 32'(1));
    step(1, 0, 1);
    step(1, 0, 1);
    chk("r_busy_c", 32'(busy0), 32'(1));
    chk("r_out_c",  32'(out0),  32'(0));
    step(1, 0, 1);
    chk("r_out_d",  32'(out0),  32'(1));
    chk("r_rise_d", 32'(rise0), 32'(1));
    chk("r_busy_d", 32'(busy0), 32'(0));
    step(1, 0, 1);
    chk("r_rise_e", 32'(rise0), 32'(0));

    // fall then rise
    repeat (4) step(0, 0, 1);
    chk("f_out",  32'(out0),  32'(0));
    chk("f_fall", 32'(fall0), 32'(1));
    repeat (4) step(1, 0, 1);
    chk("f_rise", 32'(rise0), 32'(1));
    repeat (4) step(0, 0, 1);

    // glitches from out=0: saturate at 3
    for (int g = 1; g <= 5; g++) begin
      step(1, 0, 1);
      step(1, 0, 1);
      step(0, 0, 1);
      chk("g_out",  32'(out0),  32'(0));
      chk("g_busy", 32'(busy0), 32'(0));
      chk("g_cnt",  32'(gc0),   32'((g < 3) ? g : 3));
    end

    // clear colliding with a glitch at count 2
    step(0, 1, 1);
    chk("clr_a", 32'(gc0), 32'(0));
    repeat (2) begin step(1, 0, 1); step(1, 0, 1); step(0, 0, 1); end
    chk("clr_b", 32'(gc0), 32'(2));
    step(1, 0, 1);
    step(1, 0, 1);
    step(0, 1, 1);
    chk("clr_c", 32'(gc0), 32'(0));

    // toggling every cycle never moves out
    for (int t = 0; t < 12; t++) step(bit'(t % 2 == 0), 0, 1);
    chk("tog_out", 32'(out0), 32'(0));

    // reset mid-pending
    step(0, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    chk("mr_out",  32'(out0),  32'(0));
    chk("mr_busy", 32'(busy0), 32'(0));
    chk("mr_rise", 32'(rise0), 32'(0));
    repeat (3) step(1, 0, 1);
    chk("mr_out3", 32'(out0), 32'(0));
    step(1, 0, 1);
    chk("mr_out4", 32'(out0), 32'(1));

    // random runs of varying length
    cur = 1'b0;
    hold = 0;
    for (int r = 0; r < 3000; r++) begin
      if (hold == 0) begin
        cur  = bit'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 6));
      end
      hold--;
      step(cur, bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 299) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sig_debounce.md
SIG_DEBOUNCE -- requirements
Module: sig_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive samples that must differ from out before out changes.
REQ-002 Parameter CNT_W, default 16: width of the internal stability counter.
REQ-003 Parameter GLITCH_W, default 8: width of glitch_cnt.
REQ-004 Parameter RST_LEVEL, default 1'b0: value of out after reset.
REQ-005 clk  input  1  sampling clock, the same domain as the upstream level synchronizer output.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in  input  1  level signal, already synchronized to clk.
REQ-008 glitch_clr  input  1  synchronous clear for glitch_cnt.
REQ-009 out  output  1  debounced level, registered.
REQ-010 rise  output  1  one-cycle pulse, asserted in the cycle out goes 0->1.
REQ-011 fall  output  1  one-cycle pulse, asserted in the cycle out goes 1->0.
REQ-012 busy  output  1  high while a transition is pending (a PEND state).
REQ-013 glitch_cnt  output  GLITCH_W  saturating count of aborted transitions.

Function
REQ-014 The design SHALL raise an elaboration error if STABLE_CYCLES < 1 or if STABLE_CYCLES > 2**CNT_W.
REQ-015 The FSM SHALL have four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-016 The state SHALL always agree with out: out=0 in STABLE_LO and PEND_HI, and out=1 in STABLE_HI and PEND_LO.
REQ-017 The counter SHALL track consecutive in samples that differ from out.
REQ-018 In a STABLE state with in==out, the state SHALL be held and the counter SHALL stay at 0.
REQ-019 In a STABLE state with in!=out and STABLE_CYCLES==1: out SHALL toggle at that edge, the pulse SHALL assert, and the state SHALL stay STABLE with the new level.
REQ-020 In a STABLE state with in!=out and STABLE_CYCLES>1: the state SHALL move to PEND and the counter SHALL become 1.
REQ-021 In PEND with in!=out and counter < STABLE_CYCLES-1, the counter SHALL increment.
REQ-022 In PEND with in!=out and counter == STABLE_CYCLES-1: out SHALL toggle, the state SHALL become the opposite STABLE state, the counter SHALL clear, and rise/fall SHALL assert for exactly one cycle.
REQ-023 In PEND with in==out (glitch): the state SHALL return to the current STABLE state, the counter SHALL clear, out SHALL be unchanged, and a glitch event SHALL be generated.
REQ-024 Latency: if in changes before edge k and holds, out SHALL update at edge k+STABLE_CYCLES-1, with the pulse high during the following cycle.
REQ-025 rise, fall and busy SHALL be registered.
REQ-026 rise and fall SHALL never be high together.
REQ-027 Each pulse SHALL last exactly one cycle per out transition.
REQ-028 busy SHALL be high exactly in the cycles where the state is PEND_HI or PEND_LO.
REQ-029 glitch_cnt SHALL increment by 1 per glitch event and SHALL saturate at 2**GLITCH_W-1 without wrapping.
REQ-030 If glitch_clr and a glitch event occur in the same cycle, glitch_clr SHALL win and glitch_cnt SHALL become 0.
REQ-031 An input toggling every cycle SHALL never change out, and SHALL generate one glitch event per aborted PEND.
REQ-032 The counter SHALL never exceed STABLE_CYCLES-1, so no counter overflow is possible.

Reset
REQ-033 While rst_n==0 at a clk edge: out=RST_LEVEL, state=STABLE_LO if RST_LEVEL==0 else STABLE_HI, counter=0, rise=fall=busy=0, glitch_cnt=0.
REQ-034 Reset asserted mid-PEND SHALL abort the transition without any pulse or glitch event.
REQ-035 After reset is released, in SHALL be evaluated from the first edge under REQ-018 to REQ-023; an in that differs from RST_LEVEL SHALL follow the normal PEND path.

Verification (STABLE_CYCLES=4, GLITCH_W=2, RST_LEVEL=0)
REQ-036 Rise: reset, then in=1 held -> busy high for 3 cycles, out=1 at the 4th edge, rise high for one cycle, fall stays 0.
REQ-037 Glitch: from out=0, in=1 for 2 cycles then in=0 -> out stays 0, no pulse, glitch_cnt=1, busy drops.
REQ-038 Saturation: 5 consecutive 2-cycle glitches -> glitch_cnt reads 1, 2, 3, 3, 3.
REQ-039 Clear collision: glitch_clr asserted in the same cycle as a glitch event with glitch_cnt=2 -> glitch_cnt=0 the next cycle.
REQ-040 Fall: from out=1, in=0 for 4 cycles -> out=0, fall pulse for one cycle; then in=1 held 4 cycles -> rise pulse.
REQ-041 Reset mid-operation: in=1 for 3 cycles, rst_n=0 on the 3rd edge -> out=0, busy=0, no rise; after release with in=1 held, out=1 four edges later.
